// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command-driven accumulator sequencer on the initiator side of the ALU
// Runs 1..2^REP_W ALU iterations per command and returns the accumulator and flags over a result handshake.
module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int REP_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic [REP_W-1:0] cmd_repeat,
  output logic [WIDTH-1:0] alu_in_a,
  output logic [WIDTH-1:0] alu_in_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero_in,
  input  logic             alu_carry_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_carry,
  output logic             res_err
);

  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [3:0] OP_PASS = 4'h0;
  localparam logic [3:0] OP_LAST = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      op_q      <= '0;
      operand_q <= '0;
      rep_q     <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      rep_q     <= rep_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    operand_d = operand_q;
    rep_d     = rep_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_opcode;
          operand_d = cmd_operand;
          rep_d     = cmd_repeat;
          if (cmd_opcode == OP_LOAD) begin
            acc_d   = cmd_operand;
            zero_d  = (cmd_operand == '0);
            carry_d = 1'b0;
            err_d   = 1'b0;
            state_d = S_DONE;
          end else if (cmd_opcode > OP_LAST) begin
            // Illegal command: report it but leave accumulator and flags alone.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        acc_d   = alu_result;
        zero_d  = alu_zero_in;
        carry_d = alu_carry_in;
        if (rep_q == '0) begin
          state_d = S_DONE;
        end else begin
          rep_d = rep_q - REP_W'(1);
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outside EXEC the ALU is parked on pass-through so its outputs are harmless.
  assign alu_in_a   = acc_q;
  assign alu_in_b   = operand_q;
  assign alu_opcode = (state_q == S_EXEC) ? op_q : OP_PASS;

  assign cmd_ready  = (state_q == S_IDLE);
  assign res_valid  = (state_q == S_DONE);
  assign res_data   = acc_q;
  assign res_zero   = zero_q;
  assign res_carry  = carry_q;
  assign res_err    = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a behavioural ALU and reference model
// Directed test-plan steps followed by randomized commands checked against an arithmetic model.
module tb_alu_sequencer;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_operand;
  logic [2:0] cmd_repeat;
  logic [7:0] alu_in_a;
  logic [7:0] alu_in_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_zero_in;
  logic       alu_carry_in;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_zero;
  logic       res_carry;
  logic       res_err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_acc;
  logic       m_zero, m_carry, m_err;

  alu_sequencer #(.WIDTH(8), .REP_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand), .cmd_repeat(cmd_repeat),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero_in(alu_zero_in), .alu_carry_in(alu_carry_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_carry(res_carry), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour: returns {zero, carry, out[7:0]}.
  function automatic logic [9:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    case (op)
      4'h0: r = {1'b0, a};
      4'h1: r = {1'b0, a} + {1'b0, b};
      4'h2: r = {1'b0, a} - {1'b0, b};
      4'h3: r = {1'b0, a} + 9'd1;
      4'h4: r = {1'b0, a} - 9'd1;
      4'h5: r = {1'b0, a | b};
      4'h6: r = {1'b0, a & b};
      4'h7: r = {1'b0, a ^ b};
      4'h8: r = {a[0], 1'b0, a[7:1]};
      4'h9: r = {a, 1'b0};
      4'hA: r = {1'b0, ~a};
      4'hB: r = 9'd0 - {1'b0, a};
      default: r = 9'd0;
    endcase
    return {(r[7:0] == 8'd0), r};
  endfunction

  always_comb {alu_zero_in, alu_carry_in, alu_result} = alu_ref(alu_opcode, alu_in_a, alu_in_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_cmd(input logic [3:0] op, input logic [7:0] opnd, input logic [2:0] rep);
    logic [9:0] r;
    if (op == 4'h0) begin
      m_acc = opnd; m_zero = (opnd == 8'd0); m_carry = 1'b0; m_err = 1'b0;
    end else if (op > 4'hB) begin
      m_err = 1'b1;
    end else begin
      m_err = 1'b0;
      for (int i = 0; i <= int'(rep); i++) begin
        r = alu_ref(op, m_acc, opnd);
        m_acc = r[7:0]; m_carry = r[8]; m_zero = r[9];
      end
    end
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [7:0] opnd, input logic [2:0] rep, input int stall);
    int n, lat, opc, exp_lat, exp_opc;
    logic is_alu;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_operand = opnd; cmd_repeat = rep;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_opcode = 4'($urandom); cmd_operand = 8'($urandom); cmd_repeat = 3'($urandom);
    model_cmd(op, opnd, rep);
    is_alu  = (op != 4'h0) && (op <= 4'hB);
    exp_lat = is_alu ? int'(rep) + 2 : 1;
    exp_opc = is_alu ? int'(rep) + 1 : 0;
    lat = 1; opc = 0;
    while (!res_valid && lat < 20) begin
      check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      if (alu_opcode === op) opc++;
      @(posedge clk); #1; lat++;
    end
    check("res_valid", {31'd0, res_valid}, 32'd1);
    check("latency", lat, exp_lat);
    check("exec_cycles", opc, exp_opc);
    check("res_data", {24'd0, res_data}, {24'd0, m_acc});
    check("res_zero", {31'd0, res_zero}, {31'd0, m_zero});
    check("res_carry", {31'd0, res_carry}, {31'd0, m_carry});
    check("res_err", {31'd0, res_err}, {31'd0, m_err});
    for (int s = 0; s < stall; s++) begin
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", {31'd0, res_valid}, 32'd1);
      check("hold_data", {24'd0, res_data}, {24'd0, m_acc});
      check("hold_flags", {29'd0, res_zero, res_carry, res_err}, {29'd0, m_zero, m_carry, m_err});
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("res_valid_drop", {31'd0, res_valid}, 32'd0);
    check("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 4'h0; cmd_operand = 8'h00;
    cmd_repeat = 3'd0; res_ready = 1'b0;
    m_acc = 8'h00; m_zero = 1'b0; m_carry = 1'b0; m_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", {24'd0, res_data}, 32'd0);
    check("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_flags", {29'd0, res_zero, res_carry, res_err}, 32'd0);

    run_cmd(4'h0, 8'h7F, 3'd0, 0);
    run_cmd(4'h1, 8'h01, 3'd0, 0);
    run_cmd(4'h0, 8'hFF, 3'd5, 0);
    run_cmd(4'h3, 8'h00, 3'd0, 0);
    run_cmd(4'h0, 8'h05, 3'd0, 0);
    run_cmd(4'h2, 8'h06, 3'd0, 5);
    run_cmd(4'h0, 8'h01, 3'd0, 0);
    run_cmd(4'h9, 8'h00, 3'd7, 0);
    run_cmd(4'h0, 8'h3C, 3'd0, 0);
    run_cmd(4'hD, 8'h11, 3'd4, 2);

    // Reset during the third EXEC cycle of a long shift.
    run_cmd(4'h0, 8'h01, 3'd0, 0);
    cmd_valid = 1'b1; cmd_opcode = 4'h9; cmd_operand = 8'h00; cmd_repeat = 3'd7;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_exec_opcode", {28'd0, alu_opcode}, 32'h9);
    reset_n = 1'b0;
    #1;
    check("rst_mid_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_mid_acc", {24'd0, res_data}, 32'd0);
    check("rst_mid_opcode", {28'd0, alu_opcode}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_acc = 8'h00; m_zero = 1'b0; m_carry = 1'b0; m_err = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_mid_flags", {29'd0, res_zero, res_carry, res_err}, 32'd0);

    // Accumulator must start from zero after reset: ADD shows it.
    run_cmd(4'h1, 8'h2A, 3'd1, 0);

    for (int k = 0; k < 80; k++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      run_cmd(op, 8'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-driven controller that sits on the initiator side of the 8-bit ALU interface (in_a, in_b, opcode in; alu_out, alu_zero, alu_carry back).
- Holds an 8-bit accumulator and accepts commands over a valid/ready handshake.
- Drives the ALU with accumulator, operand and opcode for 1..8 repeated cycles, writing each result back to the accumulator.
- Returns final accumulator and flags over a valid/ready result handshake; feeds register-file/CPU-datapath work built on the ALU.

Parameters:
- WIDTH, 8, datapath width; must equal ALU width.
- REP_W, 3, width of repeat field; iterations = cmd_repeat + 1.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept command.
- cmd_opcode  in  4  0x0 = LOAD; 0x1-0xB = ALU op codes (add, sub, inc, dec, or, and, xor, shr, shl, ones-comp, twos-comp); 0xC-0xF illegal.
- cmd_operand  in  WIDTH  operand (in_b, or LOAD value).
- cmd_repeat  in  REP_W  extra iterations.
- alu_in_a  out  WIDTH  to ALU in_a.
- alu_in_b  out  WIDTH  to ALU in_b.
- alu_opcode  out  4  to ALU opcode.
- alu_result  in  WIDTH  from ALU alu_out.
- alu_zero_in  in  1  from ALU alu_zero.
- alu_carry_in  in  1  from ALU alu_carry.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_data  out  WIDTH  accumulator value.
- res_zero  out  1  zero flag.
- res_carry  out  1  carry flag.
- res_err  out  1  command was illegal.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; acc, op_reg, operand_reg, rep_cnt, res_zero, res_carry, res_err = 0.
  - res_valid = 0; cmd_ready = 1 once reset releases.
- States: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready at edge T: register opcode, operand and repeat.
  - LOAD: acc <= operand, zero <= (operand==0), carry <= 0; go to DONE.
  - Illegal opcode: err <= 1; acc and flags unchanged; go to DONE.
  - Otherwise: err <= 0, rep_cnt <= cmd_repeat; go to EXEC.
- EXEC:
  - alu_in_a=acc, alu_in_b=operand_reg, alu_opcode=op_reg.
  - Each edge: acc <= alu_result, zero <= alu_zero_in, carry <= alu_carry_in.
  - If rep_cnt==0, go to DONE; else rep_cnt decrements.
  - Exactly cmd_repeat+1 iterations; flags reflect the last iteration only.
- DONE:
  - res_valid=1; res_data=acc, plus flags and err, all held stable until res_ready.
  - On res_valid&&res_ready, go to IDLE.
  - cmd_ready=0 in EXEC and DONE; no command overlap.
- Latency: command accepted at edge T.
  - LOAD or illegal: res_valid at T+1.
  - ALU op: res_valid at T+1+(repeat+1).
  - Minimum command-to-command spacing: 2 cycles (LOAD with res_ready held high).
- Outside EXEC: alu_opcode=0x0 (ALU passes in_a), alu_in_a=acc, alu_in_b=operand_reg; ALU results ignored.
- Accumulator persists across commands; only reset clears it.
- cmd_repeat is ignored for LOAD and illegal opcodes.
- Width rules:
  - All arithmetic is done by the ALU; 9-bit {carry,out} semantics come from the ALU.
  - The sequencer never modifies alu_result.
- Reset mid-EXEC or mid-DONE:
  - Immediate return to IDLE with reset values; the pending result is lost and res_valid drops asynchronously.
- res_ready high while not in DONE: ignored.
- cmd_valid held while cmd_ready=0: ignored, not queued.

Test Plan:
- LOAD 0x7F, then ADD 0x01 repeat 0 -> res_data 0x80, zero 0, carry 0; ADD res_valid exactly 2 cycles after accept.
- LOAD 0xFF, INC repeat 0 -> res_data 0x00, zero 1, carry 1.
- LOAD 0x05, SUB 0x06 -> res_data 0xFF, carry 1, zero 0.
- LOAD 0x01, SHL repeat 7:
  - res_valid at T+9.
  - alu_opcode=0x9 for exactly 8 cycles.
  - Final res_data 0x00, carry 1, zero 1.
- Backpressure:
  - Hold res_ready=0 for 5 cycles after res_valid -> res_data and flags stable, cmd_ready=0 throughout.
  - Complete on res_ready=1; cmd_ready=1 on the next cycle.
- Illegal and reset:
  - LOAD 0x3C, then opcode 0xD -> res_err 1, res_data 0x3C at T+1.
  - Start SHL repeat 7, assert reset_n=0 in the 3rd EXEC cycle -> immediate IDLE, acc 0x00, res_valid 0, cmd_ready 1 after release.
